fifo_rd_pack_n: RTL and testbench
=================================

FIFO_RD_PACK_N -- requirements
Module: fifo_rd_pack_n

Interface
REQ-001 Parameter IN_W, default 32, input word width in bits, legal range >=1.
REQ-002 Parameter RATIO, default 4, input words per output word, legal range >=2; OUT_W = IN_W*RATIO.
REQ-003 Parameter MSW_FIRST, default 1; 1 = first popped word lands in the most significant slot, 0 = first popped word lands in the least significant slot.
REQ-004 The design uses one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 idata  input  IN_W  head word of the upstream FIFO.
REQ-008 i_control  input  1  control flag accompanying idata.
REQ-009 i_rdy  input  1  upstream FIFO non-empty; idata and i_control are valid.
REQ-010 pop  output  1  combinational; dequeue the upstream head word this cycle.
REQ-011 flush  input  1  discard the partially assembled word.
REQ-012 odata  output  OUT_W  assembled word, registered.
REQ-013 o_control  output  1  i_control captured with slot-0 word, registered.
REQ-014 o_rdy  output  1  registered; odata and o_control are valid.
REQ-015 pull  input  1  consumer takes odata; effective only when o_rdy=1.
REQ-016 o_partial  output  1  registered; 1 while slot count is nonzero.

Function
REQ-017 Two storage stages: an assembly register (RATIO slots plus a captured control bit) and an output register (odata, o_control, o_rdy), so assembly continues while output awaits pull.
REQ-018 Slot counter cnt runs 0..RATIO-1 and indexes the next slot to fill.
REQ-019 pull_eff = pull & o_rdy; pull while o_rdy=0 is ignored with no state change.
REQ-020 pop = i_rdy & ~flush & ~reset & (cnt!=RATIO-1 | ~o_rdy | pull_eff).
REQ-021 On pop with MSW_FIRST=1, idata writes bits [OUT_W-1-cnt*IN_W -: IN_W]; with MSW_FIRST=0, idata writes bits [cnt*IN_W +: IN_W].
REQ-022 On pop with cnt=0, i_control is captured for the word being assembled; i_control on later slots is ignored.
REQ-023 On pop with cnt<RATIO-1, cnt increments by 1.
REQ-024 On pop with cnt=RATIO-1, the full word (final slot included) and its captured control load into the output register next edge, o_rdy=1, cnt=0.
REQ-025 Completion and pull_eff in the same cycle: the output register loads the new word and o_rdy stays 1; no bubble and no loss.
REQ-026 pull_eff without completion: o_rdy=0 next cycle; odata retains its last value.
REQ-027 Last word pending (cnt=RATIO-1) with o_rdy=1 and no pull: pop=0 and the assembly register stalls; no overwrite.
REQ-028 With i_rdy=1 and pull held at 1, one output word every RATIO cycles; first o_rdy occurs RATIO cycles after the first pop.
REQ-029 flush: cnt=0 next cycle and partial contents are discarded; pop=0 that cycle; the output register, o_rdy and pull handling are unaffected.
REQ-030 flush and pull_eff in the same cycle: both take effect.
REQ-031 o_partial = (cnt!=0), registered.

Reset
REQ-032 On reset: cnt=0, o_rdy=0, o_partial=0, odata=0, o_control=0, and the assembly register and captured control are 0.
REQ-033 reset during assembly discards partial data; pop=0 while reset=1.
REQ-034 The first pop occurs no earlier than the first cycle after reset deasserts.

Verification
REQ-035 Defaults, MSW_FIRST=1; i_rdy=1; words 0x11111111, 0x22222222, 0x33333333, 0x44444444; i_control=1 on the first word only -> 4 pops; odata=0x11111111_22222222_33333333_44444444, o_control=1, o_rdy=1.
REQ-036 Same words with MSW_FIRST=0 -> odata=0x44444444_33333333_22222222_11111111.
REQ-037 pull=0, 8 words available -> 4 pops, first word held, then 3 further pops and pop=0 with cnt=3; after pull: second word loads, o_rdy stays 1.
REQ-038 i_rdy=1, pull=1 continuously, 12 words -> 3 outputs, o_rdy never drops after the first, pop high every cycle.
REQ-039 Pop 2 words, pulse flush, pop 4 words A..D -> odata={A,B,C,D}, o_partial=1 after 2 pops and 0 after flush.
REQ-040 Assert reset with cnt=2 and o_rdy=1 -> next cycle o_rdy=0, odata=0, o_partial=0; no pop while reset=1.

Source files
------------

// File: rtl/fifo_rd_pack_n.sv
// ============================================================================
// Module   : fifo_rd_pack_n
// Purpose  : Pops RATIO narrow words from an upstream FIFO and packs them into
//            one wide output word, with a separate output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_pack_n #(
    parameter int IN_W      = 32,
    parameter int RATIO     = 4,
    parameter int MSW_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       idata,
    input  logic                  i_control,
    input  logic                  i_rdy,
    output logic                  pop,
    input  logic                  flush,
    output logic [IN_W*RATIO-1:0] odata,
    output logic                  o_control,
    output logic                  o_rdy,
    input  logic                  pull,
    output logic                  o_partial
);

    localparam int c_OUT_W = IN_W * RATIO;
    localparam int c_CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(RATIO - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_OUT_W-1:0] r_asm;
    logic               r_asm_ctrl;

    logic               w_pull_eff;
    logic               w_last;
    logic               w_pop;
    logic               w_complete;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_OUT_W-1:0] w_asm_next;

    assign w_pull_eff = pull & o_rdy;
    assign w_last     = (r_cnt == c_LAST);
    // The final slot may only be taken when the output register can accept the word.
    assign w_pop      = i_rdy & ~flush & ~reset & (~w_last | ~o_rdy | w_pull_eff);
    assign w_complete = w_pop & w_last;
    assign pop        = w_pop;

    // Assembly contents including the slot being written this cycle.
    for (genvar s = 0; s < RATIO; s++) begin : g_slot
        localparam int c_POS = (MSW_FIRST != 0) ? (RATIO - 1 - s) : s;
        assign w_asm_next[c_POS*IN_W +: IN_W] =
            (w_pop && (r_cnt == c_CNT_W'(s))) ? idata : r_asm[c_POS*IN_W +: IN_W];
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (flush) begin
            w_cnt_next = '0;
        end else if (w_pop) begin
            w_cnt_next = w_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_asm_ctrl <= 1'b0;
            odata      <= '0;
            o_control  <= 1'b0;
            o_rdy      <= 1'b0;
            o_partial  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            o_partial <= (w_cnt_next != '0);

            if (flush) begin
                r_asm      <= '0;
                r_asm_ctrl <= 1'b0;
            end else if (w_pop) begin
                r_asm <= w_asm_next;
                if (r_cnt == '0) begin
                    r_asm_ctrl <= i_control;
                end
            end

            if (w_complete) begin
                odata     <= w_asm_next;
                o_control <= r_asm_ctrl;
                o_rdy     <= 1'b1;
            end else if (w_pull_eff) begin
                o_rdy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_pack_n.sv
// ============================================================================
// Module   : tb_fifo_rd_pack_n
// Purpose  : Directed self-checking bench for fifo_rd_pack_n (both slot orders).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_pack_n;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         pull;
    logic [31:0]  idata;
    logic         i_control;
    logic         i_rdy;
    logic         pop_m, pop_l;
    logic [127:0] odata_m, odata_l;
    logic         octl_m, octl_l;
    logic         ordy_m, ordy_l;
    logic         opart_m, opart_l;

    logic [31:0]  mem [0:63];
    logic         cmem [0:63];
    int           rd_ptr = 0;
    int           wr_ptr = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    // Upstream FIFO model shared by both instances
    assign i_rdy     = (rd_ptr != wr_ptr);
    assign idata     = mem[rd_ptr];
    assign i_control = cmem[rd_ptr];
    always @(posedge clk) if (pop_m) rd_ptr <= rd_ptr + 1;

    fifo_rd_pack_n #(.IN_W(32), .RATIO(4), .MSW_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .idata(idata), .i_control(i_control),
        .i_rdy(i_rdy), .pop(pop_m), .flush(flush), .odata(odata_m),
        .o_control(octl_m), .o_rdy(ordy_m), .pull(pull), .o_partial(opart_m));

    fifo_rd_pack_n #(.IN_W(32), .RATIO(4), .MSW_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .idata(idata), .i_control(i_control),
        .i_rdy(i_rdy), .pop(pop_l), .flush(flush), .odata(odata_l),
        .o_control(octl_l), .o_rdy(ordy_l), .pull(pull), .o_partial(opart_l));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic c);
        mem[wr_ptr]  = w;
        cmem[wr_ptr] = c;
        wr_ptr++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] msw(input int b);
        return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
    endfunction

    function automatic logic [127:0] lsw(input int b);
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = '0;
            cmem[i] = 1'b0;
        end
        reset = 1'b1; flush = 1'b0; pull = 1'b0;
        push(32'h11111111, 1'b1); push(32'h22222222, 1'b0);
        push(32'h33333333, 1'b0); push(32'h44444444, 1'b0);

        // Reset state
        tick(1);
        chk("pop_in_reset", 128'(pop_m), 128'(1'b0));
        tick(1);
        chk("rst_odata", odata_m, 128'h0);
        chk("rst_ordy", 128'(ordy_m), 128'(1'b0));
        chk("rst_opart", 128'(opart_m), 128'(1'b0));
        chk("rst_octl", 128'(octl_m), 128'(1'b0));
        chk("rst_rdptr", 128'(rd_ptr), 128'(0));

        // Basic pack, both slot orders
        reset = 1'b0;
        #1;
        chk("first_pop", 128'(pop_m), 128'(1'b1));
        tick(2);
        chk("partial_2", 128'(opart_m), 128'(1'b1));
        tick(2);
        chk("basic_ordy", 128'(ordy_m), 128'(1'b1));
        chk("basic_msw", odata_m, 128'h11111111_22222222_33333333_44444444);
        chk("basic_lsw", odata_l, 128'h44444444_33333333_22222222_11111111);
        chk("basic_octl", 128'(octl_m), 128'(1'b1));
        chk("basic_opart", 128'(opart_m), 128'(1'b0));

        // Output held, assembly stalls on last slot
        for (int i = 0; i < 8; i++) push(32'hA0000000 + 32'(i), (i == 0));
        tick(3);
        chk("stall_pop", 128'(pop_m), 128'(1'b0));
        chk("stall_ptr", 128'(rd_ptr), 128'(7));
        tick(2);
        chk("stall_ptr2", 128'(rd_ptr), 128'(7));
        chk("stall_hold", odata_m, 128'h11111111_22222222_33333333_44444444);
        chk("stall_part", 128'(opart_m), 128'(1'b1));
        pull = 1'b1;
        #1;
        chk("pull_pop", 128'(pop_m), 128'(1'b1));
        tick(1);
        pull = 1'b0;
        chk("swap_ordy", 128'(ordy_m), 128'(1'b1));
        chk("swap_data", odata_m, msw(4));
        chk("swap_octl", 128'(octl_m), 128'(1'b1));
        pull = 1'b1;
        tick(1);
        pull = 1'b0;
        chk("pull_drop", 128'(ordy_m), 128'(1'b0));
        chk("pull_keep", odata_m, msw(4));
        chk("pull_part", 128'(opart_m), 128'(1'b1));
        tick(3);
        chk("w3_ordy", 128'(ordy_m), 128'(1'b1));
        chk("w3_data", odata_m, msw(8));
        chk("w3_octl", 128'(octl_m), 128'(1'b0));
        pull = 1'b1;
        tick(1);
        pull = 1'b0;
        chk("drain_ordy", 128'(ordy_m), 128'(1'b0));

        // Continuous streaming with pull held high
        for (int i = 0; i < 12; i++) push(32'hC0000000 + 32'(i), (i == 4));
        pull = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            #1;
            chk("stream_pop", 128'(pop_m), 128'(1'b1));
            chk("stream_popl", 128'(pop_l), 128'(pop_m));
            tick(1);
            if (k % 4 == 0) begin
                chk("stream_ordy", 128'(ordy_m), 128'(1'b1));
                chk("stream_data", odata_m, msw(12 + k - 4));
                chk("stream_octl", 128'(octl_m), 128'(k == 8));
            end
        end
        tick(1);
        pull = 1'b0;
        chk("stream_end", 128'(ordy_m), 128'(1'b0));

        // Flush discards partial word
        push(32'hD0000000, 1'b0); push(32'hD0000001, 1'b0);
        tick(2);
        chk("fl_part1", 128'(opart_m), 128'(1'b1));
        push(32'hAAAAAAAA, 1'b1); push(32'hBBBBBBBB, 1'b0);
        push(32'hCCCCCCCC, 1'b0); push(32'hDDDDDDDD, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_pop", 128'(pop_m), 128'(1'b0));
        tick(1);
        flush = 1'b0;
        chk("fl_part0", 128'(opart_m), 128'(1'b0));
        chk("fl_ptr", 128'(rd_ptr), 128'(26));
        tick(4);
        chk("fl_msw", odata_m, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        chk("fl_lsw", odata_l, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        chk("fl_octl", 128'(octl_m), 128'(1'b1));
        chk("fl_ordy", 128'(ordy_m), 128'(1'b1));

        // Flush and pull together
        push(32'hE0000000, 1'b0); push(32'hE0000001, 1'b0);
        tick(2);
        flush = 1'b1; pull = 1'b1;
        tick(1);
        flush = 1'b0; pull = 1'b0;
        chk("fp_ordy", 128'(ordy_m), 128'(1'b0));
        chk("fp_part", 128'(opart_m), 128'(1'b0));
        chk("fp_data", odata_m, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);

        // Reset mid-assembly with a word pending
        for (int i = 0; i < 6; i++) push(32'hF0000000 + 32'(i), 1'b0);
        tick(4);
        chk("rs_ordy1", 128'(ordy_m), 128'(1'b1));
        chk("rs_data1", odata_m, msw(32));
        tick(2);
        chk("rs_part1", 128'(opart_m), 128'(1'b1));
        for (int i = 0; i < 4; i++) push(32'h90000000 + 32'(i), 1'b0);
        reset = 1'b1;
        #1;
        chk("rs_pop0", 128'(pop_m), 128'(1'b0));
        tick(1);
        chk("rs_ordy", 128'(ordy_m), 128'(1'b0));
        chk("rs_odata", odata_m, 128'h0);
        chk("rs_part", 128'(opart_m), 128'(1'b0));
        chk("rs_pop1", 128'(pop_m), 128'(1'b0));
        tick(1);
        reset = 1'b0;
        tick(4);
        chk("rs_after", odata_m, msw(38));
        chk("rs_after_rdy", 128'(ordy_m), 128'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
